// File: rtl/code_tx.sv
// Serial code transmitter: shifts a captured code field out MSB-first on a/a_valid.
// Optional macro CODE_TX_REPEAT_EN adds the rpt port and inter-copy GAP state.
module code_tx #(
  parameter int CODE_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CODE_W-1:0] code,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
`ifdef CODE_TX_REPEAT_EN
  input  logic [3:0]        rpt,
`endif
  output logic              a,
  output logic              a_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
`ifdef CODE_TX_REPEAT_EN
    ,
    S_GAP  = 2'd3
`endif
  } state_t;

  localparam logic [LEN_W-1:0] L_CODE_W = LEN_W'(CODE_W);
  localparam logic [LEN_W-1:0] L_ONE    = LEN_W'(1);

  state_t              r_state, w_state_next;
  logic [CODE_W-1:0]   r_code, w_code_next;
  logic [LEN_W-1:0]    r_cnt, w_cnt_next;
  logic                r_a, w_a_next;
  logic                r_a_valid, w_a_valid_next;
  logic                r_busy, w_busy_next;
  logic                r_done, w_done_next;
`ifdef CODE_TX_REPEAT_EN
  logic [LEN_W-1:0]    r_len, w_len_next;
  logic [3:0]          r_rpt, w_rpt_next;
`endif

  logic [LEN_W-1:0]    w_len_clamped;
  logic [CODE_W-1:0]   w_shifted;
  logic                w_bit;

  assign w_len_clamped = (len > L_CODE_W) ? L_CODE_W : len;
  assign w_shifted     = r_code >> r_cnt;
  assign w_bit         = w_shifted[0];

  // Outputs are registered from the current state, so they trail the state by one cycle.
  always_comb begin
    w_state_next   = r_state;
    w_code_next    = r_code;
    w_cnt_next     = r_cnt;
    w_a_next       = 1'b0;
    w_a_valid_next = 1'b0;
    w_busy_next    = 1'b0;
    w_done_next    = 1'b0;
`ifdef CODE_TX_REPEAT_EN
    w_len_next     = r_len;
    w_rpt_next     = r_rpt;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_code_next = code;
`ifdef CODE_TX_REPEAT_EN
          w_len_next  = w_len_clamped;
          w_rpt_next  = rpt;
`endif
          if (w_len_clamped == '0) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_SEND;
            w_cnt_next   = w_len_clamped - L_ONE;
          end
        end
      end
      S_SEND: begin
        if (abort) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_a_next       = w_bit;
          w_a_valid_next = 1'b1;
          w_busy_next    = 1'b1;
          if (r_cnt == '0) begin
`ifdef CODE_TX_REPEAT_EN
            if (r_rpt != 4'd0) begin
              w_state_next = S_GAP;
              w_rpt_next   = r_rpt - 4'd1;
              w_cnt_next   = r_len - L_ONE;
            end else begin
              w_state_next = S_DONE;
            end
`else
            w_state_next = S_DONE;
`endif
          end else begin
            w_cnt_next = r_cnt - L_ONE;
          end
        end
      end
`ifdef CODE_TX_REPEAT_EN
      S_GAP: begin
        if (abort) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_busy_next  = 1'b1;
          w_state_next = S_SEND;
        end
      end
`endif
      S_DONE: begin
        w_done_next  = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_code    <= '0;
      r_cnt     <= '0;
      r_a       <= 1'b0;
      r_a_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef CODE_TX_REPEAT_EN
      r_len     <= '0;
      r_rpt     <= '0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_code    <= w_code_next;
      r_cnt     <= w_cnt_next;
      r_a       <= w_a_next;
      r_a_valid <= w_a_valid_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
`ifdef CODE_TX_REPEAT_EN
      r_len     <= w_len_next;
      r_rpt     <= w_rpt_next;
`endif
    end
  end

  assign a       = r_a;
  assign a_valid = r_a_valid;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_code_tx.sv
// Directed bench for code_tx: vector table of sends plus hand-written abort/reset/repeat sequences.
module tb_code_tx;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] code;
  logic [3:0] len;
  logic       abort;
  logic       a, a_valid, busy, done;
`ifdef CODE_TX_REPEAT_EN
  logic [3:0] rpt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  code_tx #(.CODE_W(8), .LEN_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .code(code), .len(len), .abort(abort),
`ifdef CODE_TX_REPEAT_EN
    .rpt(rpt),
`endif
    .a(a), .a_valid(a_valid), .busy(busy), .done(done)
  );

  typedef struct {
    logic [7:0] code;
    logic [3:0] len;
    int         n;
    logic [7:0] pat;
    logic       with_abort;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, " a"}, {31'd0, a}, 32'd0);
    chk({name, " a_valid"}, {31'd0, a_valid}, 32'd0);
    chk({name, " busy"}, {31'd0, busy}, 32'd0);
    chk({name, " done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic run_send(input logic [7:0] c, input logic [3:0] l, input int n,
                          input logic [7:0] pat, input logic ab, input string tag);
    @(negedge clk);
    start = 1'b1; code = c; len = l; abort = ab;
`ifdef CODE_TX_REPEAT_EN
    rpt = 4'd0;
`endif
    @(negedge clk);
    start = 1'b0; abort = 1'b0; code = ~c; len = 4'd3;
    chk({tag, " a_valid@t"}, {31'd0, a_valid}, 32'd0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start = (k == 1);
      chk({tag, " a_valid"}, {31'd0, a_valid}, 32'd1);
      chk({tag, " a"}, {31'd0, a}, {31'd0, pat[n-1-k]});
      chk({tag, " busy"}, {31'd0, busy}, 32'd1);
      chk({tag, " done early"}, {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " busy@done"}, {31'd0, busy}, 32'd0);
    chk({tag, " a_valid@done"}, {31'd0, a_valid}, 32'd0);
    chk({tag, " a@done"}, {31'd0, a}, 32'd0);
    @(negedge clk);
    chk_idle({tag, " after"});
    $display("send %s code=%02h len=%0d bits=%0d", tag, c, l, n);
  endtask

  task automatic abort_at(input int bit_idx, input logic exp_done, input string tag);
    @(negedge clk);
    start = 1'b1; code = 8'h19; len = 4'd5;
`ifdef CODE_TX_REPEAT_EN
    rpt = 4'd0;
`endif
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= bit_idx; k++) @(negedge clk);
    chk({tag, " a_valid before abort"}, {31'd0, a_valid}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk({tag, " a"}, {31'd0, a}, 32'd0);
    chk({tag, " a_valid"}, {31'd0, a_valid}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " done"}, {31'd0, done}, {31'd0, exp_done});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_idle({tag, " quiet"});
    end
    $display("abort %s at bit %0d done_expected=%0d", tag, bit_idx, exp_done);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{8'h19, 4'd5,  5, 8'h19, 1'b0};
    vecs[1] = '{8'hFF, 4'd0,  0, 8'h00, 1'b0};
    vecs[2] = '{8'hA5, 4'd12, 8, 8'hA5, 1'b0};
    vecs[3] = '{8'hFF, 4'd1,  1, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 4'd8,  8, 8'h80, 1'b0};
    vecs[5] = '{8'h5A, 4'd3,  3, 8'h02, 1'b0};
    vecs[6] = '{8'h19, 4'd5,  5, 8'h19, 1'b1};
    vecs[7] = '{8'hC3, 4'd15, 8, 8'hC3, 1'b0};

    reset_n = 1'b0; start = 1'b0; code = 8'h00; len = 4'd0; abort = 1'b0;
`ifdef CODE_TX_REPEAT_EN
    rpt = 4'd0;
`endif
    repeat (2) @(negedge clk);
    chk_idle("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_send(vecs[i].code, vecs[i].len, vecs[i].n, vecs[i].pat, vecs[i].with_abort,
               $sformatf("vec%0d", i));

    abort_at(2, 1'b0, "third_bit");
    run_send(8'h19, 4'd5, 5, 8'h19, 1'b0, "after_abort");
    abort_at(3, 1'b0, "last_bit_pending");
    abort_at(4, 1'b1, "in_done");

    // Asynchronous reset asserted between clock edges during a send.
    @(negedge clk);
    start = 1'b1; code = 8'h19; len = 4'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre-reset a_valid", {31'd0, a_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1 chk_idle("async reset");
    @(negedge clk);
    reset_n = 1'b1;
    $display("reset mid-send applied");
    run_send(8'h19, 4'd5, 5, 8'h19, 1'b0, "after_reset");

`ifdef CODE_TX_REPEAT_EN
    @(negedge clk);
    start = 1'b1; code = 8'h03; len = 4'd2; rpt = 4'd1;
    @(negedge clk);
    start = 1'b0; rpt = 4'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 2) begin
        chk("rpt gap a_valid", {31'd0, a_valid}, 32'd0);
        chk("rpt gap a", {31'd0, a}, 32'd0);
        chk("rpt gap busy", {31'd0, busy}, 32'd1);
      end else begin
        chk("rpt a_valid", {31'd0, a_valid}, 32'd1);
        chk("rpt a", {31'd0, a}, 32'd1);
      end
      chk("rpt done early", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    chk("rpt done", {31'd0, done}, 32'd1);
    chk("rpt busy@done", {31'd0, busy}, 32'd0);
    $display("repeat code=03 len=2 rpt=1");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
